rom_seq_player: RTL

- Sequencer for the 256x2 pattern ROM, which has synchronous read, one-cycle latency, no output register, and a synchronous active-high reset.
- Walks a programmable address window at a programmable pace.
- Presents each 2-bit symbol on a valid/ready stream to the downstream consumer, for example an LED or GPIO pattern driver in the bare-metal FPGA top.
- Supports one-shot and looping playback, abort, and a done pulse.

---
 rtl/rom_seq_player_pkg.sv | 18 +
 rtl/rom_seq_player_pacer.sv | 38 +++
 rtl/rom_seq_player.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rom_seq_player_pkg.sv
// Shared definitions for the ROM pattern sequencer: default widths,
// ROM geometry and the sequencer state encoding.
package rom_seq_player_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 2;
  localparam int DEF_DIV_W  = 16;
  localparam int ROM_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READ  = 3'd2,
    ST_OUT   = 3'd3,
    ST_PACE  = 3'd4
  } state_e;

endpackage

// File: rtl/rom_seq_player_pacer.sv
// Loadable down-counter with zero flag; paces the gap between an accepted
// symbol and the next ROM fetch. The count saturates at zero.
module rom_seq_pacer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: load wins over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_seq_player.sv
// Plays a window of a synchronous-read pattern ROM out on a valid/ready
// symbol stream, one-shot or looping, with a programmable gap per symbol.
//
// Stream handshake: a symbol transfers on any rising clk edge where
// sym_valid && sym_ready. sym_valid is a register, never a function of
// sym_ready, and once raised it stays high with sym_data frozen until the
// transfer (or an abort, which drops it without changing sym_data).
module rom_seq_player
  import rom_seq_player_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  step_div,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rst,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] sym_data,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [DIV_W-1:0]  step_div_q, step_div_d;
  logic              loop_en_q, loop_en_d;
  logic [DATA_W-1:0] sym_data_q, sym_data_d;
  logic              sym_valid_q, sym_valid_d;
  logic              done_q, done_d;
  logic              pace_load;
  logic              pace_dec;
  logic              pace_zero;

  rom_seq_pacer #(.DIV_W(DIV_W)) u_pacer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pace_load),
    .load_val_i(step_div_q),
    .dec_i     (pace_dec),
    .zero_o    (pace_zero)
  );

  // Next-state and datapath decisions; abort overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rom_addr_d   = rom_addr_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    step_div_d   = step_div_q;
    loop_en_d    = loop_en_q;
    sym_data_d   = sym_data_q;
    sym_valid_d  = sym_valid_q;
    done_d       = 1'b0;
    pace_load    = 1'b0;
    pace_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          start_addr_d = start_addr;
          end_addr_d   = end_addr;
          step_div_d   = step_div;
          loop_en_d    = loop_en;
          cur_addr_d   = start_addr;
          rom_addr_d   = start_addr;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        sym_data_d  = rom_dout;
        sym_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (sym_valid_q && sym_ready) begin
          sym_valid_d = 1'b0;
          pace_load   = 1'b1;
          state_d     = ST_PACE;
        end
      end
      ST_PACE: begin
        if (!pace_zero) begin
          pace_dec = 1'b1;
        end else if (cur_addr_q != end_addr_q) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          rom_addr_d = cur_addr_q + ADDR_W'(1);
          state_d    = ST_FETCH;
        end else if (loop_en_q) begin
          cur_addr_d = start_addr_q;
          rom_addr_d = start_addr_q;
          state_d    = ST_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      sym_valid_d = 1'b0;
      done_d      = 1'b0;
      pace_load   = 1'b0;
      pace_dec    = 1'b0;
      cur_addr_d  = cur_addr_q;
      rom_addr_d  = rom_addr_q;
    end
  end

  // State, address, latched configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      rom_addr_q   <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      step_div_q   <= '0;
      loop_en_q    <= 1'b0;
      sym_data_q   <= '0;
      sym_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      rom_addr_q   <= rom_addr_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      step_div_q   <= step_div_d;
      loop_en_q    <= loop_en_d;
      sym_data_q   <= sym_data_d;
      sym_valid_q  <= sym_valid_d;
      done_q       <= done_d;
    end
  end

  // ROM is held in reset only while idle, so FETCH issues a real read.
  assign rom_rst   = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = rom_addr_q;
  assign sym_data  = sym_data_q;
  assign sym_valid = sym_valid_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
